// File: rtl/dvi_timing_ctrl_pkg.sv
// Shared video timing types: per-axis timing struct, the 640x480@60 defaults
// and small helpers for deriving axis totals and counter widths.
package dvi_timing_ctrl_pkg;

  // One axis of a video mode: active span followed by front porch, sync, back porch.
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock).
  localparam timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

  // Pixel as delivered by the source, {R, G, B}.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int axis_total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic int axis_width(timing_t t);
    return $clog2(axis_total(t));
  endfunction

endpackage

// File: rtl/dvi_timing_ctrl_if.sv
// Pixel stream handshake between a show-ahead pixel source and the timing core.
interface dvi_timing_ctrl_if;
  import dvi_timing_ctrl_pkg::*;

  logic pix_valid;  // source has a pixel at its head
  rgb_t pix_data;   // head pixel, {R, G, B}
  logic pix_req;    // core consumes the head pixel this cycle

  modport master (output pix_valid, output pix_data, input pix_req);
  modport slave  (input pix_valid, input pix_data, output pix_req);

endinterface

// File: rtl/dvi_timing_ctrl_timing_axis.sv
// One timing axis: wrap counter over active/fp/sync/bp with region decode.
// Used once for the horizontal axis (steps every clock) and once for the
// vertical axis (steps on horizontal wrap).
module dvi_timing_ctrl_timing_axis
  import dvi_timing_ctrl_pkg::*;
#(
  parameter timing_t T  = VGA_640X480_H,
  localparam int     CW = axis_width(T)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_step,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap,
  output logic          o_active,
  output logic          o_sync
);

  localparam int            TOTAL    = axis_total(T);
  localparam int            SYNC_BEG = T.active + T.fp;
  localparam int            SYNC_END = SYNC_BEG + T.sync;
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  // Next count: clear parks the axis at 0, otherwise step and wrap after back porch.
  always_comb begin
    at_last = (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (i_clr)       cnt_d = '0;
    else if (i_step) cnt_d = at_last ? '0 : cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_cnt    = cnt_q;
  assign o_wrap   = i_step & at_last;
  assign o_active = int'(cnt_q) < T.active;
  assign o_sync   = (int'(cnt_q) >= SYNC_BEG) && (int'(cnt_q) < SYNC_END);

endmodule

// File: rtl/dvi_timing_ctrl.sv
// DVI/VGA timing controller: walks the raster, pulls pixels from a show-ahead
// source during the active window and presents registered TMDS-encoder inputs
// (data, control, blanking select). Missing pixels are replaced by BLANK_RGB
// and latched in a sticky underrun flag; the raster never stalls.
module dvi_timing_ctrl
  import dvi_timing_ctrl_pkg::*;
#(
  parameter int          H_ACTIVE  = VGA_640X480_H.active,
  parameter int          H_FP      = VGA_640X480_H.fp,
  parameter int          H_SYNC    = VGA_640X480_H.sync,
  parameter int          H_BP      = VGA_640X480_H.bp,
  parameter int          V_ACTIVE  = VGA_640X480_V.active,
  parameter int          V_FP      = VGA_640X480_V.fp,
  parameter int          V_SYNC    = VGA_640X480_V.sync,
  parameter int          V_BP      = VGA_640X480_V.bp,
  parameter bit          SYNC_POL  = 1'b0,
  parameter logic [23:0] BLANK_RGB = 24'h000000
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  dvi_timing_ctrl_if.slave            pix,
  output logic [$clog2(H_ACTIVE)-1:0] o_x,
  output logic [$clog2(V_ACTIVE)-1:0] o_y,
  output logic                        o_frame_start,
  output logic                        o_line_start,
  output logic [7:0]                  o_ch0_data,
  output logic [7:0]                  o_ch1_data,
  output logic [7:0]                  o_ch2_data,
  output logic [1:0]                  o_ch0_ctrl,
  output logic [1:0]                  o_ch1_ctrl,
  output logic [1:0]                  o_ch2_ctrl,
  output logic                        o_blanking,
  output logic                        o_underrun
);

  localparam timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int      HW  = axis_width(H_T);
  localparam int      VW  = axis_width(V_T);
  localparam int      XW  = $clog2(H_ACTIVE);
  localparam int      YW  = $clog2(V_ACTIVE);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, h_active, h_sync;
  logic          v_wrap_unused, v_active, v_sync;

  logic          run, active, pix_req, underrun;
  logic          hsync, vsync;

  rgb_t          rgb_q, rgb_d;
  logic          blank_q, blank_d;
  logic [1:0]    ctrl0_q, ctrl0_d;
  logic          underrun_q, underrun_d;

  // Counters are held at 0 while disabled so enabling starts on pixel (0,0).
  dvi_timing_ctrl_timing_axis #(.T(H_T)) u_h_axis (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (~i_en),
    .i_step   (1'b1),
    .o_cnt    (h_cnt),
    .o_wrap   (h_wrap),
    .o_active (h_active),
    .o_sync   (h_sync)
  );

  dvi_timing_ctrl_timing_axis #(.T(V_T)) u_v_axis (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (~i_en),
    .i_step   (h_wrap),
    .o_cnt    (v_cnt),
    .o_wrap   (v_wrap_unused),
    .o_active (v_active),
    .o_sync   (v_sync)
  );

  // Same-cycle request, position and start pulses decoded from counter state.
  always_comb begin
    run           = i_en & ~i_rst;
    active        = h_active & v_active;
    pix_req       = active & run;
    underrun      = pix_req & ~pix.pix_valid;
    o_x           = pix_req ? h_cnt[XW-1:0] : '0;
    o_y           = pix_req ? v_cnt[YW-1:0] : '0;
    o_line_start  = pix_req & (h_cnt == '0);
    o_frame_start = o_line_start & (v_cnt == '0);
  end

  assign pix.pix_req = pix_req;

  // Encoder inputs for the next cycle: pixel or blank colour, syncs, blanking select.
  always_comb begin
    rgb_d = '0;
    if (pix_req) rgb_d = pix.pix_valid ? pix.pix_data : rgb_t'(BLANK_RGB);
    blank_d    = ~pix_req;
    hsync      = (run & h_sync) ? SYNC_POL : ~SYNC_POL;
    vsync      = (run & v_sync) ? SYNC_POL : ~SYNC_POL;
    ctrl0_d    = {vsync, hsync};
    underrun_d = underrun_q | underrun;
  end

  // Encoder-side registers; underrun stays set until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_q      <= '0;
      blank_q    <= 1'b1;
      ctrl0_q    <= {2{~SYNC_POL}};
      underrun_q <= 1'b0;
    end else begin
      rgb_q      <= rgb_d;
      blank_q    <= blank_d;
      ctrl0_q    <= ctrl0_d;
      underrun_q <= underrun_d;
    end
  end

  assign o_ch2_data = rgb_q.r;
  assign o_ch1_data = rgb_q.g;
  assign o_ch0_data = rgb_q.b;
  assign o_ch0_ctrl = ctrl0_q;
  assign o_ch1_ctrl = 2'b00;
  assign o_ch2_ctrl = 2'b00;
  assign o_blanking = blank_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Bench for dvi_timing_ctrl on a tiny 4x3 raster (H 4/1/2/1, V 3/1/1/1):
// stimulus pushes the pixel the encoder must show, a negedge monitor pops it
// whenever blanking is low; timing outputs are checked against a frame-position
// count and a few hand-picked raster points.
module tb_dvi_timing_ctrl;
  import dvi_timing_ctrl_pkg::*;

  localparam logic [23:0] BLANK = 24'h5A5A5A;

  logic       i_clk = 1'b0;
  logic       i_rst, i_en;
  logic [1:0] o_x, o_y;
  logic       o_frame_start, o_line_start, o_blanking, o_underrun;
  logic [7:0] o_ch0_data, o_ch1_data, o_ch2_data;
  logic [1:0] o_ch0_ctrl, o_ch1_ctrl, o_ch2_ctrl;

  dvi_timing_ctrl_if pix ();

  dvi_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .BLANK_RGB(BLANK)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .pix(pix),
    .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start), .o_line_start(o_line_start),
    .o_ch0_data(o_ch0_data), .o_ch1_data(o_ch1_data), .o_ch2_data(o_ch2_data),
    .o_ch0_ctrl(o_ch0_ctrl), .o_ch1_ctrl(o_ch1_ctrl), .o_ch2_ctrl(o_ch2_ctrl),
    .o_blanking(o_blanking), .o_underrun(o_underrun)
  );

  always #5 i_clk = ~i_clk;

  int          n_chk = 0, n_fail = 0;
  logic [23:0] src_q[$];   // show-ahead pixel source contents
  logic [23:0] exp_q[$];   // pixels the encoder must present, in order
  bit          force_low = 1'b0;
  int          k = 0;      // expected raster position within the 48-cycle frame
  int          n_req, n_fs, n_ls;
  logic        last_fs;
  logic [1:0]  exp_ctrl_r = 2'b11;
  logic        exp_blank_r = 1'b1, exp_unr_r = 1'b0, exp_rst_r = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    pix.pix_valid = !force_low && (src_q.size() > 0);
    pix.pix_data  = (src_q.size() > 0) ? src_q[0] : 24'h0;
  endtask

  // One clock: drive source, check at negedge, account the edge, return at posedge+1.
  task automatic cyc();
    bit run, act, ereq, xfer;
    int eh, ev;
    drive_src();
    @(negedge i_clk);
    run  = i_en && !i_rst;
    eh   = k % 8;
    ev   = k / 8;
    act  = (eh < 4) && (ev < 3);
    ereq = act && run;
    chk("pix_req",     32'(pix.pix_req),    32'(ereq));
    chk("frame_start", 32'(o_frame_start),  32'(ereq && k == 0));
    chk("line_start",  32'(o_line_start),   32'(ereq && eh == 0));
    chk("o_x",         32'(o_x),            ereq ? 32'(eh) : 32'd0);
    chk("o_y",         32'(o_y),            ereq ? 32'(ev) : 32'd0);
    chk("ch0_ctrl",    32'(o_ch0_ctrl),     32'(exp_ctrl_r));
    chk("ch12_ctrl",   32'({o_ch2_ctrl, o_ch1_ctrl}), 32'd0);
    chk("blanking",    32'(o_blanking),     32'(exp_blank_r));
    chk("underrun",    32'(o_underrun),     32'(exp_unr_r));
    if (exp_rst_r) chk("rst_data", 32'({o_ch2_data, o_ch1_data, o_ch0_data}), 32'd0);
    n_req  += int'(pix.pix_req);
    n_fs   += int'(o_frame_start);
    n_ls   += int'(o_line_start);
    last_fs = o_frame_start;
    xfer    = pix.pix_req && pix.pix_valid;
    if (ereq) exp_q.push_back(pix.pix_valid ? 24'(pix.pix_data) : BLANK);
    @(posedge i_clk);
    if (xfer) void'(src_q.pop_front());
    exp_ctrl_r  = {(run && ev == 4) ? 1'b0 : 1'b1, (run && eh >= 5 && eh <= 6) ? 1'b0 : 1'b1};
    exp_blank_r = !ereq;
    exp_unr_r   = i_rst ? 1'b0 : (exp_unr_r | (ereq && !pix.pix_valid));
    exp_rst_r   = i_rst;
    k           = run ? (k + 1) % 48 : 0;
    #1;
  endtask

  // Monitor: every unblanked encoder cycle must carry the next expected pixel.
  always @(negedge i_clk) begin
    if (o_blanking === 1'b0) begin
      if (exp_q.size() == 0) chk("pix_extra", 32'd1, 32'd0);
      else chk("pix_data", 32'({o_ch2_data, o_ch1_data, o_ch0_data}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1;
    i_en  = 1'b0;
    for (int i = 0; i < 35; i++) src_q.push_back(i == 0 ? 24'hAABBCC : (24'h400000 | 24'(i)));

    // Reset state, then reset with enable high must still not request.
    repeat (3) cyc();
    chk("rst_ctrl0",    32'(o_ch0_ctrl), 32'h3);
    chk("rst_blanking", 32'(o_blanking), 32'h1);
    chk("rst_underrun", 32'(o_underrun), 32'h0);
    i_en  = 1'b1;
    n_req = 0;
    repeat (2) cyc();
    chk("req_in_rst", 32'(n_req), 32'd0);

    // Two full frames with a always-valid source.
    i_rst = 1'b0;
    for (int i = 0; i < 96; i++) begin
      if (i % 48 == 0) begin n_req = 0; n_fs = 0; n_ls = 0; end
      cyc();
      if (i == 0) begin
        chk("pix00_ch2", 32'(o_ch2_data), 32'hAA);
        chk("pix00_ch1", 32'(o_ch1_data), 32'hBB);
        chk("pix00_ch0", 32'(o_ch0_data), 32'hCC);
        chk("pix00_blank", 32'(o_blanking), 32'h0);
      end
      if (i == 4)  chk("h4_ctrl",  32'(o_ch0_ctrl), 32'h3);
      if (i == 5)  chk("h5_ctrl",  32'(o_ch0_ctrl), 32'h2);
      if (i == 6)  chk("h6_ctrl",  32'(o_ch0_ctrl), 32'h2);
      if (i == 7)  chk("h7_ctrl",  32'(o_ch0_ctrl), 32'h3);
      if (i == 36) chk("v4h4_ctrl", 32'(o_ch0_ctrl), 32'h1);
      if (i == 37) begin
        chk("v4h5_ctrl",  32'(o_ch0_ctrl), 32'h0);
        chk("v4h5_blank", 32'(o_blanking), 32'h1);
      end
      if (i % 48 == 47) begin
        chk("req_per_frame",  32'(n_req), 32'd12);
        chk("fs_per_frame",   32'(n_fs),  32'd1);
        chk("ls_per_frame",   32'(n_ls),  32'd3);
        chk("no_underrun",    32'(o_underrun), 32'h0);
      end
    end

    // Third frame: source empty on pixel (1,0).
    n_req = 0; n_fs = 0; n_ls = 0;
    for (int i = 0; i < 48; i++) begin
      force_low = (i == 1);
      cyc();
      if (i == 0) chk("unr_before", 32'(o_underrun), 32'h0);
      if (i == 1) begin
        chk("unr_set",   32'(o_underrun), 32'h1);
        chk("unr_rgb",   32'({o_ch2_data, o_ch1_data, o_ch0_data}), 32'(BLANK));
        chk("unr_blank", 32'(o_blanking), 32'h0);
      end
    end
    force_low = 1'b0;
    chk("unr_held",      32'(o_underrun), 32'h1);
    chk("unr_frame_req", 32'(n_req), 32'd12);
    chk("unr_frame_fs",  32'(n_fs),  32'd1);

    // Reset pulse while the raster sits on h=3, v=2.
    repeat (19) cyc();
    i_rst = 1'b1;
    cyc();
    chk("midrst_ctrl0",    32'(o_ch0_ctrl), 32'h3);
    chk("midrst_underrun", 32'(o_underrun), 32'h0);
    chk("midrst_blank",    32'(o_blanking), 32'h1);
    repeat (2) cyc();
    i_rst = 1'b0;
    cyc();
    chk("fs_after_rst", 32'(last_fs), 32'h1);
    repeat (29) cyc();

    // Disable for 20 cycles, then re-enable.
    i_en  = 1'b0;
    n_req = 0;
    repeat (20) cyc();
    chk("req_while_dis",   32'(n_req), 32'd0);
    chk("blank_while_dis", 32'(o_blanking), 32'h1);
    chk("ctrl_while_dis",  32'(o_ch0_ctrl), 32'h3);
    i_en = 1'b1;
    cyc();
    chk("fs_after_en", 32'(last_fs), 32'h1);
    repeat (19) cyc();
    i_en = 1'b0;
    repeat (3) cyc();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
